// File: rtl/yarvi_bus_arbiter.sv
// Two-master bus arbiter for yarvi_soc: m0 = htif host, m1 = yarvi core data port.
// Define YARVI_ARB_FIXED_PRIO_EN to make m0 always win when unlocked (default: round-robin).
module yarvi_bus_arbiter #(
    parameter int OUTST_LOG2 = 2
) (
    input  logic                  clock,
    input  logic                  reset,

    output logic                  m0_req_ready,
    input  logic                  m0_req_read,
    input  logic                  m0_req_write,
    input  logic [31:0]           m0_req_address,
    input  logic [31:0]           m0_req_data,
    output logic                  m0_res_valid,
    output logic [31:0]           m0_res_data,

    output logic                  m1_req_ready,
    input  logic                  m1_req_read,
    input  logic                  m1_req_write,
    input  logic [31:0]           m1_req_address,
    input  logic [31:0]           m1_req_data,
    output logic                  m1_res_valid,
    output logic [31:0]           m1_res_data,

    input  logic                  s_req_ready,
    output logic                  s_req_read,
    output logic                  s_req_write,
    output logic [31:0]           s_req_address,
    output logic [31:0]           s_req_data,
    input  logic                  s_res_valid,
    input  logic [31:0]           s_res_data,

    output logic [OUTST_LOG2:0]   outstanding,
    output logic                  err
);

    localparam int unsigned DEPTH = 1 << OUTST_LOG2;

    typedef enum logic [1:0] {
        ARB_FREE    = 2'd0,
        ARB_LOCK_M0 = 2'd1,
        ARB_LOCK_M1 = 2'd2
    } arb_state_t;

    arb_state_t state, state_nxt;

    logic                  req0, req1;
    logic                  grant_valid;
    logic                  grant_id;
    logic                  favour_m1;
    logic                  sel_read, sel_write;
    logic [31:0]           sel_address, sel_data;
    logic                  fifo_full, fifo_empty;
    logic                  xfer;
    logic                  push, pop;
    logic                  head_id;

    logic                  tag_mem [DEPTH];
    logic [OUTST_LOG2-1:0] rd_ptr, wr_ptr;
    logic [OUTST_LOG2:0]   count;

    assign req0 = m0_req_read | m0_req_write;
    assign req1 = m1_req_read | m1_req_write;

`ifdef YARVI_ARB_FIXED_PRIO_EN
    assign favour_m1 = 1'b0;
`else
    logic rr_m1;

    assign favour_m1 = rr_m1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_m1 <= 1'b0;
        end else if (xfer) begin
            rr_m1 <= ~grant_id;
        end
    end
`endif

    // A lock follows the locked master's request; if it drops, the lock is released.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        case (state)
            ARB_LOCK_M0: begin
                grant_valid = req0;
                grant_id    = 1'b0;
            end
            ARB_LOCK_M1: begin
                grant_valid = req1;
                grant_id    = 1'b1;
            end
            default: begin
                if (req0 && req1) begin
                    grant_valid = 1'b1;
                    grant_id    = favour_m1;
                end else if (req0) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b0;
                end else if (req1) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b1;
                end
            end
        endcase
    end

    assign sel_read    = grant_id ? m1_req_read    : m0_req_read;
    assign sel_write   = grant_id ? m1_req_write   : m0_req_write;
    assign sel_address = grant_id ? m1_req_address : m0_req_address;
    assign sel_data    = grant_id ? m1_req_data    : m0_req_data;

    assign fifo_full  = (count == (OUTST_LOG2+1)'(DEPTH));
    assign fifo_empty = (count == '0);

    // Full blocks reads even when a response pops in the same cycle.
    assign xfer = reset & grant_valid & s_req_ready & ~(sel_read & fifo_full);

    assign m0_req_ready  = xfer & ~grant_id;
    assign m1_req_ready  = xfer &  grant_id;
    assign s_req_read    = xfer & sel_read;
    assign s_req_write   = xfer & sel_write;
    assign s_req_address = sel_address;
    assign s_req_data    = sel_data;

    assign push    = xfer & sel_read;
    assign pop     = reset & s_res_valid & ~fifo_empty;
    assign head_id = tag_mem[rd_ptr];

    assign m0_res_valid = pop & ~head_id;
    assign m1_res_valid = pop &  head_id;
    assign m0_res_data  = s_res_data;
    assign m1_res_data  = s_res_data;

    assign outstanding = count;

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_FREE: begin
                if (grant_valid && !xfer) begin
                    state_nxt = grant_id ? ARB_LOCK_M1 : ARB_LOCK_M0;
                end
            end
            ARB_LOCK_M0, ARB_LOCK_M1: begin
                if (xfer || !grant_valid) begin
                    state_nxt = ARB_FREE;
                end
            end
            default: state_nxt = ARB_FREE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ARB_FREE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            tag_mem[wr_ptr] <= grant_id;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (s_res_valid && fifo_empty) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_yarvi_bus_arbiter.sv
// Self-checking bench for yarvi_bus_arbiter: directed scenarios plus randomized
// traffic checked every cycle against a queue-based model of the arbiter.
module tb_yarvi_bus_arbiter;

    localparam int OUTST_LOG2 = 2;
    localparam int DEPTH      = 1 << OUTST_LOG2;
`ifdef YARVI_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req_ready, m0_req_read, m0_req_write, m0_res_valid;
    logic [31:0] m0_req_address, m0_req_data, m0_res_data;
    logic        m1_req_ready, m1_req_read, m1_req_write, m1_res_valid;
    logic [31:0] m1_req_address, m1_req_data, m1_res_data;
    logic        s_req_ready, s_req_read, s_req_write, s_res_valid;
    logic [31:0] s_req_address, s_req_data, s_res_data;
    logic [OUTST_LOG2:0] outstanding;
    logic        err;

    always #5 clock = ~clock;

    yarvi_bus_arbiter #(.OUTST_LOG2(OUTST_LOG2)) dut (
        .clock(clock), .reset(reset),
        .m0_req_ready(m0_req_ready), .m0_req_read(m0_req_read), .m0_req_write(m0_req_write),
        .m0_req_address(m0_req_address), .m0_req_data(m0_req_data),
        .m0_res_valid(m0_res_valid), .m0_res_data(m0_res_data),
        .m1_req_ready(m1_req_ready), .m1_req_read(m1_req_read), .m1_req_write(m1_req_write),
        .m1_req_address(m1_req_address), .m1_req_data(m1_req_data),
        .m1_res_valid(m1_res_valid), .m1_res_data(m1_res_data),
        .s_req_ready(s_req_ready), .s_req_read(s_req_read), .s_req_write(s_req_write),
        .s_req_address(s_req_address), .s_req_data(s_req_data),
        .s_res_valid(s_res_valid), .s_res_data(s_res_data),
        .outstanding(outstanding), .err(err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: list of masters owed a read response, sticky error, lock owner, favoured master.
    int tags[$];
    bit m_err  = 1'b0;
    int lock_m = -1;
    int fav    = 0;
    bit exp_rdy0, exp_rdy1;

    typedef struct {
        bit          active;
        bit          rd;
        logic [31:0] a;
        logic [31:0] d;
    } mreq_t;
    mreq_t pend [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic idle();
        m0_req_read = 0; m0_req_write = 0; m0_req_address = '0; m0_req_data = '0;
        m1_req_read = 0; m1_req_write = 0; m1_req_address = '0; m1_req_data = '0;
        s_req_ready = 1; s_res_valid = 0; s_res_data = '0;
    endtask

    // Settle, compare every output against the model, then advance the model one edge.
    task automatic eval();
        int g, head;
        bit r0, r1, gr, gw, full, xfer, rv;
        logic [31:0] ga, gd;
        #3;
        r0 = m0_req_read | m0_req_write;
        r1 = m1_req_read | m1_req_write;
        g = -1;
        if (lock_m >= 0) begin
            if ((lock_m == 0 && r0) || (lock_m == 1 && r1)) g = lock_m;
        end else if (r0 && r1) g = FIXED ? 0 : fav;
        else if (r0) g = 0;
        else if (r1) g = 1;
        gr = (g == 0) ? m0_req_read    : (g == 1) ? m1_req_read    : 1'b0;
        gw = (g == 0) ? m0_req_write   : (g == 1) ? m1_req_write   : 1'b0;
        ga = (g == 1) ? m1_req_address : m0_req_address;
        gd = (g == 1) ? m1_req_data    : m0_req_data;
        full = (tags.size() == DEPTH);
        xfer = reset && g >= 0 && s_req_ready && !(gr && full);
        exp_rdy0 = xfer && g == 0;
        exp_rdy1 = xfer && g == 1;
        head = (tags.size() > 0) ? tags[0] : -1;
        rv = reset && s_res_valid && head >= 0;

        chk("m0_req_ready", m0_req_ready, exp_rdy0);
        chk("m1_req_ready", m1_req_ready, exp_rdy1);
        chk("s_req_read", s_req_read, xfer && gr);
        chk("s_req_write", s_req_write, xfer && gw);
        if (g >= 0) begin
            chk("s_req_address", s_req_address, ga);
            chk("s_req_data", s_req_data, gd);
        end
        chk("m0_res_valid", m0_res_valid, rv && head == 0);
        chk("m1_res_valid", m1_res_valid, rv && head == 1);
        if (rv && head == 0) chk("m0_res_data", m0_res_data, s_res_data);
        if (rv && head == 1) chk("m1_res_data", m1_res_data, s_res_data);
        chk("outstanding", 32'(outstanding), 32'(tags.size()));
        chk("err", err, m_err);

        if (!reset) begin
            tags.delete();
            m_err = 1'b0; lock_m = -1; fav = 0;
        end else begin
            if (s_res_valid) begin
                if (tags.size() > 0) void'(tags.pop_front());
                else m_err = 1'b1;
            end
            if (xfer) begin
                if (gr) tags.push_back(g);
                lock_m = -1;
                fav = 1 - g;
            end else lock_m = g;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 0;
        idle();
        tick();

        // Reset low forces ready/valid outputs to zero.
        m0_req_read = 1; s_res_valid = 1;
        eval();
        chk("rst_m0_ready", m0_req_ready, 0);
        chk("rst_s_read", s_req_read, 0);
        chk("rst_m0_res_valid", m0_res_valid, 0);
        tick();
        idle(); eval(); tick();
        reset = 1;

        // Single m0 read, answered two cycles later.
        m0_req_read = 1; m0_req_address = 32'h100;
        eval();
        chk("t1_s_read", s_req_read, 1);
        chk("t1_m0_ready", m0_req_ready, 1);
        chk("t1_addr", s_req_address, 32'h100);
        tick();
        idle(); eval(); chk("t1_outst", 32'(outstanding), 1); tick();
        s_res_valid = 1; s_res_data = 32'hDEADBEEF;
        eval();
        chk("t1_m0_res_valid", m0_res_valid, 1);
        chk("t1_m0_res_data", m0_res_data, 32'hDEADBEEF);
        chk("t1_m1_res_valid", m1_res_valid, 0);
        tick();

        // Reset pulse brings the round-robin pointer back to m0.
        idle(); reset = 0; eval(); tick(); reset = 1;

        // Both masters read every cycle: grants alternate (or always m0 in fixed mode).
        m0_req_read = 1; m0_req_address = 32'h200;
        m1_req_read = 1; m1_req_address = 32'h300;
        for (int i = 0; i < 4; i++) begin
            eval();
            chk("t2_m0_grant", m0_req_ready, FIXED ? 1'b1 : (i % 2 == 0));
            chk("t2_m1_grant", m1_req_ready, FIXED ? 1'b0 : (i % 2 == 1));
            tick();
        end

        // FIFO full: writes still flow, reads stall until a pop has retired.
        idle(); m1_req_write = 1; m1_req_address = 32'h20; m1_req_data = 32'h77;
        eval();
        chk("t4_outst_full", 32'(outstanding), 4);
        chk("t4_write_ready", m1_req_ready, 1);
        chk("t4_s_write", s_req_write, 1);
        tick();
        idle(); m0_req_read = 1; m0_req_address = 32'h240;
        eval();
        chk("t4_read_blocked", m0_req_ready, 0);
        chk("t4_no_s_read", s_req_read, 0);
        tick();
        s_res_valid = 1; s_res_data = 32'h1;
        eval();
        chk("t4_no_bypass", m0_req_ready, 0);
        chk("t4_res0_m0", m0_res_valid, 1);
        tick();
        s_res_valid = 0;
        eval();
        chk("t4_read_after_pop", m0_req_ready, 1);
        tick();
        m0_req_read = 0;
        for (int i = 1; i <= 4; i++) begin
            s_res_valid = 1; s_res_data = 32'(i + 1);
            eval();
            chk("t4_res_m1", m1_res_valid, FIXED ? 1'b0 : (i % 2 == 1));
            chk("t4_res_m0", m0_res_valid, FIXED ? 1'b1 : (i % 2 == 0));
            tick();
        end

        // Stalled m1 write keeps the grant while m0 waits.
        idle(); s_req_ready = 0;
        m1_req_write = 1; m1_req_address = 32'h10; m1_req_data = 32'h55;
        eval(); chk("t3_stall_ready", m1_req_ready, 0); tick();
        m0_req_read = 1; m0_req_address = 32'h400;
        for (int i = 0; i < 2; i++) begin
            eval();
            chk("t3_m0_ready", m0_req_ready, 0);
            chk("t3_addr_stable", s_req_address, 32'h10);
            tick();
        end
        s_req_ready = 1;
        eval();
        chk("t3_m1_accept", m1_req_ready, 1);
        chk("t3_s_write", s_req_write, 1);
        chk("t3_s_data", s_req_data, 32'h55);
        chk("t3_m0_wait", m0_req_ready, 0);
        tick();
        m1_req_write = 0;
        eval(); chk("t3_m0_next", m0_req_ready, 1); tick();

        // Drain, then a spurious response sets sticky err.
        idle(); s_res_valid = 1; s_res_data = 32'hABCD;
        eval(); chk("t5_drain", m0_res_valid, 1); tick();
        eval();
        chk("t5_outst0", 32'(outstanding), 0);
        chk("t5_no_m0_valid", m0_res_valid, 0);
        chk("t5_no_m1_valid", m1_res_valid, 0);
        tick();
        idle();
        eval(); chk("t5_err", err, 1); tick();
        eval(); chk("t5_err_sticky", err, 1); tick();

        // Reset with three reads outstanding.
        m0_req_read = 1; m0_req_address = 32'h500;
        for (int i = 0; i < 3; i++) begin eval(); tick(); end
        reset = 0;
        eval();
        chk("t6_outst_before", 32'(outstanding), 3);
        chk("t6_ready_low", m0_req_ready, 0);
        tick();
        eval();
        chk("t6_outst_cleared", 32'(outstanding), 0);
        chk("t6_err_cleared", err, 0);
        tick();
        reset = 1; idle();

        // Randomized traffic with protocol-respecting masters.
        pend[0].active = 0; pend[1].active = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!reset) reset = ($urandom_range(1) == 0);
            else reset = ($urandom_range(399) != 0);
            for (int k = 0; k < 2; k++) begin
                if (!pend[k].active && $urandom_range(2) == 0) begin
                    pend[k].active = 1;
                    pend[k].rd = $urandom_range(1) == 0;
                    pend[k].a = $urandom;
                    pend[k].d = $urandom;
                end
            end
            m0_req_read  = pend[0].active && pend[0].rd;
            m0_req_write = pend[0].active && !pend[0].rd;
            m0_req_address = pend[0].a; m0_req_data = pend[0].d;
            m1_req_read  = pend[1].active && pend[1].rd;
            m1_req_write = pend[1].active && !pend[1].rd;
            m1_req_address = pend[1].a; m1_req_data = pend[1].d;
            s_req_ready = ($urandom_range(3) != 0);
            s_res_valid = (tags.size() > 0) ? ($urandom_range(1) == 0) : ($urandom_range(49) == 0);
            s_res_data  = $urandom;
            eval();
            if (exp_rdy0) pend[0].active = 0;
            if (exp_rdy1) pend[1].active = 0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
